// File: rtl/mips_multicycle.sv
// mips_multicycle: multi-cycle MIPS subset core (addu, subu, sll, ori, lui, lw, sw, beq, j, jal,
// jr). One shared datapath is sequenced by a FETCH/DECODE/EXEC/MEM/WB state machine. Any other
// encoding retires as a nop.
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-low reset
//   imem_req/addr/rdata/ready   instruction fetch handshake (ready ignored while req=0)
//   dmem_req/we/addr/wdata      data access request, held stable until dmem_ready=1
//   dmem_rdata/ready            load data and access-complete strobe
//   wb_valid/pc/reg/data        registered trace of every register-file write (incl. $0)
module mips_multicycle #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ready,
    output logic              wb_valid,
    output logic [31:0]       wb_pc,
    output logic [4:0]        wb_reg,
    output logic [31:0]       wb_data
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;

    typedef enum logic [3:0] {
        OpNop, OpAddu, OpSubu, OpSll, OpOri, OpLui, OpLw, OpSw, OpBeq, OpJ, OpJal, OpJr
    } op_e;

    state_e      state_q, state_d;
    // Low for the first cycle after reset so the first fetch starts on the edge after release.
    logic        armed_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ipc_q, ipc_d;      // PC of the instruction in flight (trace, jal link)
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] imm_q, imm_d;      // immediate already extended for the current op
    logic [31:0] res_q, res_d;      // ALU result, memory address or load data
    logic [31:0] gpr_q [32];
    logic        gpr_we;

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic [31:0] wb_data_q, wb_data_d;

    // Instruction fields
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    op_e         op;
    logic [4:0]  dst;
    logic [31:0] pc_plus4, jump_target;

    assign opcode      = ir_q[31:26];
    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = ir_q[15:11];
    assign shamt       = ir_q[10:6];
    assign funct       = ir_q[5:0];
    assign imm         = ir_q[15:0];
    assign pc_plus4    = pc_q + 32'd4;
    assign jump_target = {pc_plus4[31:28], ir_q[25:0], 2'b00};

    always_comb begin
        op = OpNop;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h21:   op = OpAddu;
                    6'h23:   op = OpSubu;
                    // The all-zero word is the canonical nop and retires without a write.
                    6'h00:   op = (ir_q == 32'h0) ? OpNop : OpSll;
                    6'h08:   op = OpJr;
                    default: op = OpNop;
                endcase
            end
            6'h0D:   op = OpOri;
            6'h0F:   op = OpLui;
            6'h23:   op = OpLw;
            6'h2B:   op = OpSw;
            6'h04:   op = OpBeq;
            6'h02:   op = OpJ;
            6'h03:   op = OpJal;
            default: op = OpNop;
        endcase
    end

    always_comb begin
        dst = 5'd0;
        case (op)
            OpAddu, OpSubu, OpSll: dst = rd;
            OpOri, OpLui, OpLw:    dst = rt;
            OpJal:                 dst = 5'd31;
            default:               dst = 5'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ipc_d      = ipc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        res_d      = res_q;
        gpr_we     = 1'b0;
        wb_valid_d = 1'b0;
        wb_pc_d    = wb_pc_q;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;

        unique case (state_q)
            StFetch: begin
                if (armed_q && imem_ready) begin
                    ir_d    = imem_rdata;
                    ipc_d   = pc_q;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d = gpr_q[rs];
                b_d = gpr_q[rt];
                case (op)
                    OpOri:   imm_d = {16'h0000, imm};
                    OpLui:   imm_d = {imm, 16'h0000};
                    default: imm_d = {{16{imm[15]}}, imm};
                endcase
                state_d = StExec;
            end
            StExec: begin
                state_d = StFetch;
                case (op)
                    OpAddu: begin res_d = a_q + b_q;      state_d = StWb; end
                    OpSubu: begin res_d = a_q - b_q;      state_d = StWb; end
                    OpSll:  begin res_d = b_q << shamt;   state_d = StWb; end
                    OpOri:  begin res_d = a_q | imm_q;    state_d = StWb; end
                    OpLui:  begin res_d = imm_q;          state_d = StWb; end
                    OpLw, OpSw: begin
                        res_d   = a_q + imm_q;
                        state_d = StMem;
                    end
                    OpBeq: pc_d = (a_q == b_q) ? pc_plus4 + {imm_q[29:0], 2'b00} : pc_plus4;
                    OpJ:   pc_d = jump_target;
                    OpJal: begin
                        pc_d    = jump_target;
                        res_d   = pc_plus4;
                        state_d = StWb;
                    end
                    OpJr:    pc_d = a_q;
                    default: pc_d = pc_plus4;
                endcase
            end
            StMem: begin
                if (dmem_ready) begin
                    if (op == OpSw) begin
                        pc_d    = pc_plus4;
                        state_d = StFetch;
                    end else begin
                        res_d   = dmem_rdata;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                gpr_we     = (dst != 5'd0);
                wb_valid_d = 1'b1;
                wb_pc_d    = ipc_q;
                wb_reg_d   = dst;
                wb_data_d  = res_q;
                // jal already redirected the PC in EXEC.
                if (op != OpJal) begin
                    pc_d = pc_plus4;
                end
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StFetch;
            armed_q    <= 1'b0;
            pc_q       <= PC_RESET;
            ipc_q      <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            res_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_pc_q    <= '0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= 1'b1;
            pc_q       <= pc_d;
            ipc_q      <= ipc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            res_q      <= res_d;
            wb_valid_q <= wb_valid_d;
            wb_pc_q    <= wb_pc_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // $0 is never written, so it always reads as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (gpr_we) begin
            gpr_q[dst] <= res_q;
        end
    end

    // Requests decode straight from state so an asynchronous reset drops them at once;
    // address/data buses are forced to zero whenever the matching request is idle.
    assign imem_req   = armed_q && (state_q == StFetch);
    assign imem_addr  = imem_req ? pc_q[ADDR_W-1:0] : '0;
    assign dmem_req   = (state_q == StMem);
    assign dmem_we    = dmem_req && (op == OpSw);
    assign dmem_addr  = dmem_req ? res_q[ADDR_W-1:0] : '0;
    assign dmem_wdata = dmem_req ? b_q : '0;

    assign wb_valid = wb_valid_q;
    assign wb_pc    = wb_pc_q;
    assign wb_reg   = wb_reg_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: program tables drive instruction memory and fill scoreboards for
// fetch addresses/spacing, writeback trace and data accesses; monitors compare on the falling edge.
module tb_mips_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready = 1'b0;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    mips_multicycle #(
        .ADDR_W  (32),
        .PC_RESET(32'h0000_3000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready),
        .wb_valid  (wb_valid),
        .wb_pc     (wb_pc),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        bit          has_wb;
        logic [4:0]  rd;
        logic [31:0] data;
        int          gap;    // cycles from this fetch to the next one
    } vec_t;
    typedef struct { logic [31:0] pc; logic [4:0] rd; logic [31:0] data; } wb_t;
    typedef struct { logic [31:0] addr; int gap; } fe_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int cycles; } dm_t;

    vec_t tab [0:20];
    wb_t  wb_q[$];
    fe_t  fe_q[$];
    dm_t  dm_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    int dwait    = 0;
    int dcnt     = 0;

    logic [31:0] imem_mem [0:1023];
    logic [31:0] dmem_mem [0:63];
    logic [31:0] ioff;

    assign ioff       = imem_addr - 32'h3000;
    assign imem_rdata = imem_mem[ioff[11:2]];
    assign dmem_rdata = dmem_mem[dmem_addr[7:2]];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (dmem_req && dmem_ready && dmem_we) dmem_mem[dmem_addr[7:2]] <= dmem_wdata;
    end

    // Memory handshakes: imem zero-wait, dmem ready after dwait extra cycles. Ready is left
    // high while idle since the core must ignore it then.
    always @(posedge clk) begin
        #1;
        imem_ready = imem_req;
        if (dmem_req) begin
            dmem_ready = (dcnt >= dwait);
            dcnt++;
        end else begin
            dmem_ready = 1'b1;
            dcnt = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got no matching event, expected one", name);
    endtask

    // Load table rows lo..hi into imem and queue the fetch and writeback they should produce.
    task automatic load(input int lo, input int hi, input logic [31:0] next_addr);
        logic [31:0] off;
        for (int i = lo; i <= hi; i++) begin
            off = tab[i].addr - 32'h3000;
            imem_mem[off[11:2]] = tab[i].instr;
            if (tab[i].has_wb) wb_q.push_back('{tab[i].addr, tab[i].rd, tab[i].data});
            fe_q.push_back('{tab[i].addr, (i == lo) ? 0 : tab[i-1].gap});
        end
        fe_q.push_back('{next_addr, tab[hi].gap});
    endtask

    task automatic wait_empty(input int max, input string name);
        int n;
        n = 0;
        while ((wb_q.size() != 0 || fe_q.size() != 0 || dm_q.size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (wb_q.size() != 0 || fe_q.size() != 0 || dm_q.size() != 0) fail_now(name);
    endtask

    // Monitors
    bit          ireq_prev = 1'b0;
    int          last_f    = 0;
    int          dcyc      = 0;
    bit          unstable  = 1'b0;
    logic        d_we;
    logic [31:0] d_addr, d_wd;

    always @(negedge clk) begin : mon
        fe_t f;
        wb_t w;
        dm_t d;
        if (imem_req && !ireq_prev) begin
            if (mon_en) begin
                if (fe_q.size() == 0) fail_now("fetch_unexpected");
                else begin
                    f = fe_q.pop_front();
                    check("fetch_addr", imem_addr, f.addr);
                    if (f.gap != 0) check("fetch_gap", cyc - last_f, f.gap);
                end
            end
            last_f = cyc;
        end
        ireq_prev = imem_req;

        if (wb_valid && mon_en) begin
            if (wb_q.size() == 0) fail_now("wb_unexpected");
            else begin
                w = wb_q.pop_front();
                check("wb_pc", wb_pc, w.pc);
                check("wb_reg", {27'd0, wb_reg}, {27'd0, w.rd});
                check("wb_data", wb_data, w.data);
            end
        end

        if (dmem_req) begin
            if (dcyc == 0) begin
                d_we = dmem_we; d_addr = dmem_addr; d_wd = dmem_wdata;
            end else if (dmem_we !== d_we || dmem_addr !== d_addr || dmem_wdata !== d_wd) begin
                unstable = 1'b1;
            end
            dcyc++;
            if (dmem_ready) begin
                if (mon_en) begin
                    if (dm_q.size() == 0) fail_now("dmem_unexpected");
                    else begin
                        d = dm_q.pop_front();
                        check("dmem_we", {31'd0, dmem_we}, {31'd0, d.we});
                        check("dmem_addr", dmem_addr, d.addr);
                        check("dmem_wdata", dmem_wdata, d.wdata);
                        check("dmem_req_cycles", dcyc, d.cycles);
                        check("dmem_stable", {31'd0, unstable}, 32'd0);
                    end
                end
                dcyc = 0;
                unstable = 1'b0;
            end
        end else begin
            dcyc = 0;
            unstable = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int t0;
        // Phase 1 program, in execution order
        tab[0]  = '{32'h3000, 32'h34011234, 1'b1, 5'd1,  32'h0000_1234, 4}; // ori  $1,$0,0x1234
        tab[1]  = '{32'h3004, 32'h3C02FFFF, 1'b1, 5'd2,  32'hFFFF_0000, 4}; // lui  $2,0xFFFF
        tab[2]  = '{32'h3008, 32'h00411821, 1'b1, 5'd3,  32'hFFFF_1234, 4}; // addu $3,$2,$1
        tab[3]  = '{32'h300C, 32'h00222023, 1'b1, 5'd4,  32'h0001_1234, 4}; // subu $4,$1,$2
        tab[4]  = '{32'h3010, 32'h10220005, 1'b0, 5'd0,  32'h0,         3}; // beq $1,$2,5 (no)
        tab[5]  = '{32'h3014, 32'hAC010008, 1'b0, 5'd0,  32'h0,         7}; // sw   $1,8($0)
        tab[6]  = '{32'h3018, 32'h8C050008, 1'b1, 5'd5,  32'h0000_1234, 8}; // lw   $5,8($0)
        tab[7]  = '{32'h301C, 32'h00210021, 1'b1, 5'd0,  32'h0000_2468, 4}; // addu $0,$1,$1
        tab[8]  = '{32'h3020, 32'h0C000C40, 1'b1, 5'd31, 32'h0000_3024, 4}; // jal  0x3100
        tab[9]  = '{32'h3100, 32'h00015821, 1'b1, 5'd11, 32'h0000_1234, 4}; // addu $11,$0,$1
        tab[10] = '{32'h3104, 32'h00017100, 1'b1, 5'd14, 32'h0001_2340, 4}; // sll  $14,$1,4
        tab[11] = '{32'h3108, 32'h03E00008, 1'b0, 5'd0,  32'h0,         3}; // jr   $31
        tab[12] = '{32'h3024, 32'h200C0005, 1'b0, 5'd0,  32'h0,         3}; // addi: unsupported
        tab[13] = '{32'h3028, 32'h340D0055, 1'b1, 5'd13, 32'h0000_0055, 4}; // ori  $13,$0,0x55
        tab[14] = '{32'h302C, 32'h08000C0B, 1'b0, 5'd0,  32'h0,         3}; // j    0x302C
        // Phase 2 program, run after a reset taken in the middle of a load
        tab[15] = '{32'h3000, 32'h00233021, 1'b1, 5'd6,  32'h0,         4}; // addu $6,$1,$3
        tab[16] = '{32'h3004, 32'h00853821, 1'b1, 5'd7,  32'h0,         4}; // addu $7,$4,$5
        tab[17] = '{32'h3008, 32'h34080001, 1'b1, 5'd8,  32'h1,         4}; // ori  $8,$0,1
        tab[18] = '{32'h300C, 32'h34090002, 1'b1, 5'd9,  32'h2,         4}; // ori  $9,$0,2
        tab[19] = '{32'h3010, 32'h1021FFFE, 1'b0, 5'd0,  32'h0,         3}; // beq $1,$1,-2
        tab[20] = '{32'h300C, 32'h34090002, 1'b1, 5'd9,  32'h2,         4}; // ori  $9 again

        reset = 1'b0;
        dwait = 3;
        load(0, 14, 32'h302C);
        dm_q.push_back('{1'b1, 32'h8, 32'h1234, 4});
        dm_q.push_back('{1'b0, 32'h8, 32'h0,    4});

        repeat (3) @(negedge clk);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_dmem_req_we", {30'd0, dmem_req, dmem_we}, 32'd0);
        check("rst_dmem_addr_wdata", dmem_addr | dmem_wdata, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_trace", wb_pc | {27'd0, wb_reg} | wb_data, 32'd0);

        @(negedge clk);
        mon_en = 1'b1;
        reset  = 1'b1;
        n = 0;
        while (!imem_req && n < 20) begin @(negedge clk); n++; end
        if (!imem_req) fail_now("first_fetch");
        else begin
            t0 = cyc;
            n = 0;
            while (!wb_valid && n < 20) begin @(negedge clk); n++; end
            if (!wb_valid) fail_now("first_wb");
            else check("first_wb_latency", cyc - t0, 32'd4);
        end
        wait_empty(400, "phase1_drain");
        mon_en = 1'b0;
        check("dmem_stored_word", dmem_mem[2], 32'h0000_1234);

        // Reset while a load is waiting on dmem_ready.
        @(negedge clk);
        reset = 1'b0;
        imem_mem[0] = 32'h8C010000; // lw $1,0($0)
        dwait = 50;
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        while (!dmem_req && n < 20) begin @(negedge clk); n++; end
        if (!dmem_req) fail_now("mid_mem_entry");
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("midrst_dmem_addr", dmem_addr, 32'd0);
        check("midrst_imem_req", {31'd0, imem_req}, 32'd0);
        check("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);

        dwait = 0;
        load(15, 20, 32'h3010);
        @(negedge clk);
        mon_en = 1'b1;
        reset  = 1'b1;
        wait_empty(200, "phase2_drain");
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle.md
Name: mips_multicycle

Overview:
- Multi-cycle successor to the single-cycle MIPS top. It runs a fetch/decode/execute/memory/writeback state machine over one shared datapath.
- Instruction and data memories are external and use a req/ready handshake, so memories with wait states are supported.
- Address width and reset PC are parametrised.
- A writeback trace port is provided so the bench can check every committed register write.

Parameters:
ADDR_W, 32, width of imem_addr/dmem_addr (low ADDR_W bits of the internal 32-bit byte address; 2..32)
PC_RESET, 32'h0000_3000, PC value after reset

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  instruction fetch request
imem_addr  output  ADDR_W  fetch byte address (= PC)
imem_rdata  input  32  instruction word, valid when imem_ready=1
imem_ready  input  1  fetch complete this cycle
dmem_req  output  1  data access request
dmem_we  output  1  1=store (sw), 0=load (lw)
dmem_addr  output  ADDR_W  data byte address
dmem_wdata  output  32  store data
dmem_rdata  input  32  load data, valid when dmem_ready=1
dmem_ready  input  1  data access complete this cycle
wb_valid  output  1  one-cycle pulse on each register-file write
wb_pc  output  32  PC of the committing instruction
wb_reg  output  5  destination register
wb_data  output  32  written value

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, PC=PC_RESET, all 32 GPRs=0.
  - imem_req=dmem_req=dmem_we=wb_valid=0; wb_pc/wb_reg/wb_data=0; addresses/wdata=0.
  - Reset in any state, including mid-handshake, aborts the instruction with no register or memory side effect.
  - After reset releases, FETCH begins on the next edge.
- Supported instructions: addu, subu, sll (sll $0,$0,0 = nop), ori, lui, lw, sw, beq, j, jal, jr.
  - Any other encoding executes as a nop: PC+=4, no writes.
- States:
  - FETCH: imem_req=1 and imem_addr=PC, held until imem_ready=1. On that edge IR<=imem_rdata, go to DECODE. Zero-wait is legal (ready in the first req cycle).
  - DECODE: 1 cycle. Latch A=GPR[rs], B=GPR[rt], and the extended immediate. ori uses zero-extension; beq/lw/sw use sign-extension; lui uses imm<<16.
  - EXEC: 1 cycle, ALU result latched. Exits:
    - beq: if A==B, PC<=PC+4+(sext(imm)<<2), else PC+4; go to FETCH.
    - j/jal: target {PC+4[31:28],index,2'b00}.
    - jal: go to WB with $31<=PC+4.
    - j: go to FETCH.
    - jr: PC<=A; go to FETCH.
    - lw/sw: go to MEM.
    - ALU ops: go to WB.
    - nop/unknown: PC+=4; go to FETCH.
  - MEM: dmem_req=1, dmem_addr=A+sext(imm), dmem_we=(sw), dmem_wdata=B, all held stable until dmem_ready=1. On ready:
    - sw: PC+=4; go to FETCH.
    - lw: latch dmem_rdata; go to WB.
  - WB: 1 cycle. GPR[dst]<=value, PC<=PC+4 (jal PC already set); go to FETCH. dst is rd for R-type, rt for I-type, 31 for jal.
- Timing with zero-wait memories, from fetch start to the next fetch: ALU/jal 4 cycles; lw 5; sw 4; beq/j/jr 3.
- Writes to $0 are discarded (GPR[0] always reads 0).
- Trace port:
  - wb_valid pulses for every WB, including dst=0, with wb_data = value presented.
  - wb_pc/wb_reg/wb_data are registered and change only when wb_valid=1.
- Ready ignored: imem_ready/dmem_ready are ignored while the corresponding req=0.
- Arithmetic: all 32-bit, addu/subu wrap with no overflow trap. Address outputs take the low ADDR_W bits. Misaligned lw/sw addresses are passed through unmodified.
- Register read-after-write needs no hazard logic: instructions are strictly sequential.

Test Plan:
- Reset, zero-wait memory, ori $1,$0,0x1234 at 0x3000: first imem_addr=0x3000 → wb_valid with wb_pc=0x3000, wb_reg=1, wb_data=0x00001234, 4 cycles after the fetch began.
- lui $2,0xFFFF; addu $3,$2,$1; subu $4,$1,$2 → trace 0xFFFF0000, 0xFFFF1234, 0x00011234.
- sw $1,8($0) with dmem_ready delayed 3 cycles:
  - dmem_req/we/addr=8/wdata=0x1234 held stable for 4 cycles;
  - then lw $5,8($0) → wb_data=0x1234.
- beq taken and untaken:
  - beq $1,$1,-2 at 0x3010 → next imem_addr=0x300C;
  - beq $1,$2,5 → 0x3014.
- jal at 0x3020 to 0x3100 → wb_reg=31, wb_data=0x3024, next fetch 0x3100; then jr $31 → fetch 0x3024.
- Edge cases:
  - reset=0 asserted mid-MEM with dmem_req=1 → dmem_req drops immediately; after release, fetch 0x3000 with all GPRs 0.
  - addu $0,$1,$1 → wb_valid=1, wb_reg=0, but $0 still reads 0.
  - Unknown opcode acts as a nop.
